// File: rtl/debug_loader.sv
// Host debug loader: UART-driven program load, run/step/halt control and ACK/NAK replies.
// Optional cycle counter and 'C' query are built only when DEBUG_CYCLE_CNT_EN is defined.
module debug_loader #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              enable,
   output logic              core_rst_n,
   output logic              busy
);
   // state | meaning
   // IDLE  | waiting for a command byte
   // LEN   | core held in reset, waiting for word count
   // DATA  | core held in reset, assembling and writing words
   // RUN   | pipeline free-running until 'H'
   // STEP  | single enable cycle
   // TX    | sending queued reply byte(s), then draining tx_busy

   localparam int CNT_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_RUN  = 8'h52;
   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] CMD_HALT = 8'h48;
   localparam logic [7:0] ACK      = 8'h06;
   localparam logic [7:0] NAK      = 8'h15;

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_RUN, S_STEP, S_TX} state_t;

   state_t           state;
   logic [CNT_W-1:0] words_left;
   logic [1:0]       byte_cnt;
   logic [23:0]      shift;
   logic [31:0]      tx_buf;
   logic [2:0]       tx_left;

`ifdef DEBUG_CYCLE_CNT_EN
   localparam logic [7:0] CMD_CNT = 8'h43;
   logic [31:0] cycle_cnt;
   logic        load_entry;

   assign load_entry = (state == S_IDLE) && rx_valid && (rx_data == CMD_LOAD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            cycle_cnt <= '0;
      else if (load_entry) cycle_cnt <= '0;
      else if (enable)     cycle_cnt <= cycle_cnt + 32'd1;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         enable     <= 1'b0;
         core_rst_n <= 1'b0;
         busy       <= 1'b0;
         words_left <= '0;
         byte_cnt   <= '0;
         shift      <= '0;
         tx_buf     <= '0;
         tx_left    <= '0;
      end else begin
         imem_we    <= 1'b0;
         tx_start   <= 1'b0;
         core_rst_n <= 1'b1;
         // address advances the cycle after each write strobe
         if (imem_we) imem_addr <= imem_addr + ADDR_W'(1);
         case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  case (rx_data)
                     CMD_LOAD: begin
                        state      <= S_LEN;
                        core_rst_n <= 1'b0;
                        busy       <= 1'b1;
                        imem_addr  <= '0;
                        byte_cnt   <= '0;
                     end
                     CMD_RUN: begin
                        state  <= S_RUN;
                        enable <= 1'b1;
                     end
                     CMD_STEP: begin
                        state  <= S_STEP;
                        enable <= 1'b1;
                        busy   <= 1'b1;
                     end
`ifdef DEBUG_CYCLE_CNT_EN
                     CMD_CNT: begin
                        state   <= S_TX;
                        tx_buf  <= cycle_cnt;
                        tx_left <= 3'd4;
                        busy    <= 1'b1;
                     end
`endif
                     default: begin
                        state   <= S_TX;
                        tx_buf  <= {NAK, 24'h0};
                        tx_left <= 3'd1;
                        busy    <= 1'b1;
                     end
                  endcase
               end
            end
            S_LEN: begin
               core_rst_n <= 1'b0;
               if (rx_valid) begin
                  words_left <= (rx_data == 8'h00) ? (CNT_W'(1) << ADDR_W) : CNT_W'(rx_data);
                  state      <= S_DATA;
               end
            end
            S_DATA: begin
               core_rst_n <= 1'b0;
               if (rx_valid) begin
                  shift    <= {shift[15:0], rx_data};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_wdata <= {shift, rx_data};
                     words_left <= words_left - CNT_W'(1);
                     if (words_left == CNT_W'(1)) begin
                        state      <= S_TX;
                        core_rst_n <= 1'b1;
                        tx_buf     <= {ACK, 24'h0};
                        tx_left    <= 3'd1;
                     end
                  end
               end
            end
            S_RUN: begin
               if (rx_valid && rx_data == CMD_HALT) begin
                  enable  <= 1'b0;
                  state   <= S_TX;
                  tx_buf  <= {ACK, 24'h0};
                  tx_left <= 3'd1;
                  busy    <= 1'b1;
               end
            end
            S_STEP: begin
               enable  <= 1'b0;
               state   <= S_TX;
               tx_buf  <= {ACK, 24'h0};
               tx_left <= 3'd1;
            end
            S_TX: begin
               // tx_busy lags tx_start by a cycle, so the cycle after a start is skipped
               if (!tx_busy && !tx_start) begin
                  if (tx_left != 3'd0) begin
                     tx_start <= 1'b1;
                     tx_data  <= tx_buf[31:24];
                     tx_buf   <= {tx_buf[23:0], 8'h00};
                     tx_left  <= tx_left - 3'd1;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_debug_loader.sv
// Directed self-checking bench for debug_loader with a simple UART transmitter busy model.
module tb_debug_loader;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        imem_we;
   logic [6:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        enable;
   logic        core_rst_n;
   logic        busy;

   logic hold;
   logic model_busy;
   logic busy_pend;
   int   busy_cnt;
   logic en_prev;
   int   en_cycles;
   int   en_rise;
   int   vec;
   int   miss;

   logic [7:0]  tx_q[$];
   logic [6:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   assign tx_busy = hold | model_busy;

   always #5 clk = ~clk;

   debug_loader #(.ADDR_W(7), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
      .tx_start(tx_start), .tx_data(tx_data), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .enable(enable), .core_rst_n(core_rst_n), .busy(busy)
   );

   // monitors and transmitter model: busy rises the cycle after tx_start, lasts 4 cycles
   always @(negedge clk) begin
      if (busy_pend) begin
         model_busy = 1'b1;
         busy_cnt   = 4;
         busy_pend  = 1'b0;
      end else if (busy_cnt != 0) begin
         busy_cnt = busy_cnt - 1;
         if (busy_cnt == 0) model_busy = 1'b0;
      end
      if (tx_start === 1'b1) begin
         busy_pend = 1'b1;
         tx_q.push_back(tx_data);
      end
      if (imem_we === 1'b1) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
      end
      if (enable === 1'b1) en_cycles = en_cycles + 1;
      if (enable === 1'b1 && en_prev !== 1'b1) en_rise = en_rise + 1;
      en_prev = enable;
   end

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy !== 1'b0 && n < max) begin
         @(negedge clk);
         n++;
      end
      vec++;
      if (busy !== 1'b0) begin
         miss++;
         $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vec++;
      if ({tx_start, tx_data, imem_we, imem_addr, imem_wdata, enable, core_rst_n, busy} !== '0) begin
         miss++;
         $display("FAIL reset_outputs: got ts=%0b td=%0h we=%0b a=%0h wd=%0h en=%0b crn=%0b bz=%0b, required all 0",
                  tx_start, tx_data, imem_we, imem_addr, imem_wdata, enable, core_rst_n, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      vec++;
      if (core_rst_n !== 1'b1) begin
         miss++;
         $display("FAIL reset_release: core_rst_n=%0b, required 1", core_rst_n);
      end
      vec++;
      if (busy !== 1'b0 || enable !== 1'b0) begin
         miss++;
         $display("FAIL reset_idle: busy=%0b enable=%0b, required 0 0", busy, enable);
      end
   endtask

   task automatic test_load();
      logic [7:0] bytes[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      tx_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
      send(8'h4C);
      vec++;
      if (core_rst_n !== 1'b0 || busy !== 1'b1) begin
         miss++;
         $display("FAIL load_entry: core_rst_n=%0b busy=%0b, required 0 1", core_rst_n, busy);
      end
      send(8'h02);
      for (int i = 0; i < 7; i++) send(bytes[i]);
      vec++;
      if (core_rst_n !== 1'b0 || wr_addr_q.size() != 1) begin
         miss++;
         $display("FAIL load_mid: core_rst_n=%0b writes=%0d, required 0 1", core_rst_n, wr_addr_q.size());
      end
      send(bytes[7]);
      vec++;
      if (core_rst_n !== 1'b1) begin
         miss++;
         $display("FAIL load_release: core_rst_n=%0b, required 1", core_rst_n);
      end
      wait_idle(200);
      vec++;
      if (wr_addr_q.size() != 2) begin
         miss++;
         $display("FAIL load_write_count: got %0d, required 2", wr_addr_q.size());
      end else begin
         vec++;
         if (wr_addr_q[0] !== 7'd0 || wr_data_q[0] !== 32'h01020304) begin
            miss++;
            $display("FAIL load_word0: addr %0h data %0h, required 0 01020304", wr_addr_q[0], wr_data_q[0]);
         end
         vec++;
         if (wr_addr_q[1] !== 7'd1 || wr_data_q[1] !== 32'hAABBCCDD) begin
            miss++;
            $display("FAIL load_word1: addr %0h data %0h, required 1 aabbccdd", wr_addr_q[1], wr_data_q[1]);
         end
      end
      vec++;
      if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
         miss++;
         $display("FAIL load_ack: %0d bytes first %0h, required 1 byte 06", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00);
      end
   endtask

   task automatic test_step();
      int e0 = en_cycles;
      int r0 = en_rise;
      tx_q.delete();
      send(8'h53);
      vec++;
      if (enable !== 1'b1) begin
         miss++;
         $display("FAIL step_enable_on: enable=%0b, required 1", enable);
      end
      @(negedge clk);
      vec++;
      if (enable !== 1'b0 || tx_start !== 1'b0) begin
         miss++;
         $display("FAIL step_enable_off: enable=%0b tx_start=%0b, required 0 0", enable, tx_start);
      end
      wait_idle(200);
      send(8'h53);
      wait_idle(200);
      send(8'h53);
      wait_idle(200);
      vec++;
      if (en_cycles - e0 != 3 || en_rise - r0 != 3) begin
         miss++;
         $display("FAIL step_pulses: %0d cycles %0d pulses, required 3 3", en_cycles - e0, en_rise - r0);
      end
      vec++;
      if (tx_q.size() != 3 || tx_q[0] !== 8'h06 || tx_q[1] !== 8'h06 || tx_q[2] !== 8'h06) begin
         miss++;
         $display("FAIL step_acks: got %0d bytes, required 3 x 06", tx_q.size());
      end
`ifdef DEBUG_CYCLE_CNT_EN
      tx_q.delete();
      send(8'h43);
      wait_idle(300);
      vec++;
      if (tx_q.size() != 4 || {tx_q[0], tx_q[1], tx_q[2], tx_q[3]} !== 32'h00000003) begin
         miss++;
         $display("FAIL count_bytes: got %0d bytes, required 00 00 00 03", tx_q.size());
      end
`endif
   endtask

   task automatic test_run();
      int e0 = en_cycles;
      tx_q.delete();
      send(8'h52);
      vec++;
      if (enable !== 1'b1 || busy !== 1'b0) begin
         miss++;
         $display("FAIL run_entry: enable=%0b busy=%0b, required 1 0", enable, busy);
      end
      repeat (100) @(negedge clk);
      send(8'h41);
      repeat (10) @(negedge clk);
      vec++;
      if (tx_q.size() != 0 || enable !== 1'b1) begin
         miss++;
         $display("FAIL run_ignore: tx bytes %0d enable=%0b, required 0 1", tx_q.size(), enable);
      end
      send(8'h48);
      vec++;
      if (enable !== 1'b0) begin
         miss++;
         $display("FAIL halt_enable: enable=%0b, required 0", enable);
      end
      vec++;
      if (en_cycles - e0 < 100) begin
         miss++;
         $display("FAIL run_length: enable high %0d cycles, required >= 100", en_cycles - e0);
      end
      wait_idle(200);
      vec++;
      if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
         miss++;
         $display("FAIL halt_ack: got %0d bytes, required 1 x 06", tx_q.size());
      end
   endtask

   task automatic test_nak();
      tx_q.delete();
      send(8'h7A);
      wait_idle(200);
      vec++;
      if (tx_q.size() != 1 || tx_q[0] !== 8'h15) begin
         miss++;
         $display("FAIL nak_unknown: got %0d bytes first %0h, required 1 x 15", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00);
      end
`ifndef DEBUG_CYCLE_CNT_EN
      tx_q.delete();
      send(8'h43);
      wait_idle(200);
      vec++;
      if (tx_q.size() != 1 || tx_q[0] !== 8'h15) begin
         miss++;
         $display("FAIL nak_count: got %0d bytes first %0h, required 1 x 15", tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00);
      end
`endif
   endtask

   task automatic test_reset_midload();
      logic [7:0] bytes[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      wr_addr_q.delete(); wr_data_q.delete();
      send(8'h4C);
      send(8'h02);
      for (int i = 1; i <= 5; i++) send(8'(i));
      rst = 1'b0;
      #1;
      vec++;
      if (imem_addr !== 7'd0 || core_rst_n !== 1'b0 || busy !== 1'b0 || imem_we !== 1'b0) begin
         miss++;
         $display("FAIL midload_reset: addr=%0h crn=%0b busy=%0b we=%0b, required 0 0 0 0", imem_addr, core_rst_n, busy, imem_we);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tx_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
      send(8'h4C);
      send(8'h01);
      for (int i = 0; i < 4; i++) send(bytes[i]);
      wait_idle(200);
      vec++;
      if (wr_addr_q.size() != 1) begin
         miss++;
         $display("FAIL reload_count: got %0d writes, required 1", wr_addr_q.size());
      end else begin
         vec++;
         if (wr_addr_q[0] !== 7'd0 || wr_data_q[0] !== 32'hDEADBEEF) begin
            miss++;
            $display("FAIL reload_word: addr %0h data %0h, required 0 deadbeef", wr_addr_q[0], wr_data_q[0]);
         end
      end
      vec++;
      if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
         miss++;
         $display("FAIL reload_ack: got %0d bytes, required 1 x 06", tx_q.size());
      end
   endtask

   task automatic test_hold();
      tx_q.delete();
      hold = 1'b1;
      send(8'h53);
      repeat (50) @(negedge clk);
      vec++;
      if (tx_q.size() != 0 || busy !== 1'b1) begin
         miss++;
         $display("FAIL hold_blocked: %0d starts busy=%0b, required 0 1", tx_q.size(), busy);
      end
      hold = 1'b0;
      wait_idle(200);
      vec++;
      if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
         miss++;
         $display("FAIL hold_release: got %0d starts, required 1 x 06", tx_q.size());
      end
   endtask

   initial begin
      vec = 0; miss = 0;
      rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      hold = 1'b0; model_busy = 1'b0; busy_pend = 1'b0; busy_cnt = 0;
      en_prev = 1'b0; en_cycles = 0; en_rise = 0;
      test_reset();
      test_load();
      test_step();
      test_run();
      test_nak();
      test_reset_midload();
      test_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/debug_loader.md
# debug_loader

Host-side control block sitting directly upstream of the five-stage pipeline. It takes bytes from a UART receiver, loads programs word-by-word into the fetch stage's instruction memory, and generates the pipeline `enable` and core reset. Supported modes are free-run, single-step and halt, and every host command is acknowledged through a UART transmitter.

## Interface
**Parameters**
- `ADDR_W`, 7, instruction memory address width; matches the 7-bit PC.
- `DATA_W`, 32, instruction word width; must be 32, assembled from 4 bytes.

**Ports**
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `tx_busy` in 1: transmitter busy; goes high the cycle after `tx_start`.
- `tx_start` out 1: one-cycle strobe to send `tx_data`.
- `tx_data` out 8: byte to transmit.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out `ADDR_W`: write address.
- `imem_wdata` out 32: write word.
- `enable` out 1: pipeline enable.
- `core_rst_n` out 1: active-low pipeline reset.
- `busy` out 1: high in any state except IDLE and RUN.

## Operation
- Commands are taken in IDLE only:
  - `0x4C` ('L'): load.
  - `0x52` ('R'): run.
  - `0x53` ('S'): step.
  - `0x43` ('C'): count; requires the macro below.
- Any other byte in IDLE sends NAK `0x15`.
- States: IDLE, LEN, DATA, RUN, STEP, TX.
- **Load**
  - IDLE -'L'-> LEN. The next byte is the word count N; N=0 means 2^ADDR_W words.
  - LEN -> DATA. Bytes are assembled MSB first.
  - On each 4th byte, write one word to `imem_addr`. The address starts at 0 and increments after each write.
  - After N writes -> TX with ACK `0x06`.
  - `core_rst_n`=0 throughout LEN and DATA, released on entry to TX.
- **Run**
  - IDLE -'R'-> RUN. `enable`=1 continuously.
  - In RUN, `0x48` ('H') -> `enable`=0 -> TX with ACK. All other bytes are ignored.
- **Step**
  - IDLE -'S'-> STEP. `enable`=1 for exactly one cycle -> TX with ACK.
- **TX**
  - Send the queued byte(s). `tx_start` fires only when `tx_busy`=0 and no start was issued the previous cycle.
  - After the last byte, wait for `tx_busy`=0, then -> IDLE.
  - `rx_valid` bytes arriving in TX or STEP are dropped.
- There is no timeout. A partial load stays in DATA until the remaining bytes arrive or `rst` is asserted.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `enable`=0, `core_rst_n`=0, `busy`=0, state IDLE.
  - `core_rst_n` goes to 1 on the first clock after reset deasserts.
- All outputs are registered. The response to `rx_valid` at edge k appears after edge k+1.
- `imem_we` is high for exactly one cycle, with `imem_addr` and `imem_wdata` stable in that cycle. The address increment is visible the following cycle.
- Step: `enable` is high for one cycle, starting the cycle after 'S' is sampled. `tx_start` for the ACK comes no earlier than the cycle after `enable` falls.
- Halt: `enable` is low the cycle after 'H' is sampled.
- Reset mid-operation: asynchronous return to reset values; a partial word is discarded and the load address returns to 0.
- Simultaneous `rx_valid` and `tx_busy` deassertion in TX: the byte is dropped and the TX sequence continues.

## Configuration
- Macro `DEBUG_CYCLE_CNT_EN`.
- **Defined**
  - A 32-bit counter increments on every cycle with `enable`=1. It wraps modulo 2^32 and is cleared by `rst` and by load entry.
  - 'C' in IDLE -> TX sends 4 count bytes, MSB first, snapshotted when 'C' is sampled. No ACK follows.
- **Undefined**
  - The counter is not built.
  - 'C' gets NAK `0x15`.

## Test plan
- Load N=2 with bytes `01 02 03 04 AA BB CC DD` -> two one-cycle `imem_we`: addr 0 = `0x01020304`, addr 1 = `0xAABBCCDD`; then `tx_data`=`0x06`; `core_rst_n` low from 'L' to TX.
- 'S' three times from IDLE -> exactly 3 single-cycle `enable` pulses, 3 ACKs; with the macro, 'C' then returns `00 00 00 03`.
- 'R', wait 100 cycles, 'H' -> `enable` high ≥100 cycles, low the cycle after 'H' is sampled, one ACK; a non-'H' byte during RUN produces no TX.
- Unknown byte `0x7A` in IDLE -> NAK `0x15`; without the macro, 'C' -> `0x15`.
- Assert `rst` after 5 data bytes of a load, then reload N=1 `DE AD BE EF` -> `imem_addr` 0 gets `0xDEADBEEF`; no stale bytes.
- Hold `tx_busy`=1 for 50 cycles during an ACK -> `tx_start` stays 0 until `tx_busy` falls; exactly one `tx_start` follows.
